// File: rtl/i2s_rx_deserializer.sv
// ---------------------------------------------------------------------------------------------
// i2s_rx_deserializer
//   I2S receiver acting as bus slave. The bclk/lrc/sd pins come from an external source and are
//   asynchronous to clk; they are oversampled, the bclk rising edge is detected, and MSB-first
//   words are rebuilt per channel slot. Each finished slot produces one left-justified sample
//   on a valid/ready stream backed by a single holding register.
//
// Ports
//   clk             system clock, at least 8x the bclk frequency
//   rst             synchronous, active-high reset
//   i2s_bclk_i      serial bit clock (asynchronous)
//   i2s_lrc_i       word select (asynchronous), 0 = left, 1 = right
//   i2s_sd_i        serial data (asynchronous), valid at bclk rising edge
//   sample_data_o   received word, left-justified
//   sample_right_o  channel of sample_data_o (1 = right)
//   sample_valid_o  sample_data_o/sample_right_o valid
//   sample_ready_i  consumer accepts when valid & ready at posedge clk
//   locked_o        frame alignment established and bclk active
//   overrun_o       one-cycle pulse: a finished word was dropped because the holding reg was full
//   overrun_cnt_o   saturating count of dropped words
// ---------------------------------------------------------------------------------------------
module i2s_rx_deserializer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2s_bclk_i,
  input  logic              i2s_lrc_i,
  input  logic              i2s_sd_i,
  output logic [DATA_W-1:0] sample_data_o,
  output logic              sample_right_o,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic              locked_o,
  output logic              overrun_o,
  output logic [CNT_W-1:0]  overrun_cnt_o
);

  localparam int unsigned BitCntW = $clog2(DATA_W + 1);
  localparam int unsigned ToW     = 12;

  localparam logic [BitCntW-1:0] DataWVal   = BitCntW'(DATA_W);
  localparam logic [ToW-1:0]     TimeoutVal = ToW'(TIMEOUT);

  localparam logic [0:0] StSync = 1'b0;
  localparam logic [0:0] StRecv = 1'b1;

  // Synchronisers; bclk has an extra history stage for edge detection.
  logic bclk_s1_q, bclk_s2_q, bclk_hist_q;
  logic lrc_s1_q, lrc_s2_q;
  logic sd_s1_q, sd_s2_q;

  logic               lrc_prev_q, lrc_prev_d;
  logic [0:0]         state_q, state_d;
  logic [BitCntW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [ToW-1:0]     to_q, to_d;

  logic [DATA_W-1:0]  data_q, data_d;
  logic               right_q, right_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic [CNT_W-1:0]   ovr_cnt_q, ovr_cnt_d;

  logic               bclk_evt;
  logic               boundary;
  logic               cnt_full;
  logic [DATA_W-1:0]  shreg_fin;
  logic [BitCntW-1:0] cnt_fin;
  logic               word_fire;
  logic [DATA_W-1:0]  word_data;
  logic               word_right;

  assign bclk_evt = bclk_s2_q & ~bclk_hist_q;
  assign boundary = bclk_evt & (lrc_s2_q != lrc_prev_q);
  assign cnt_full = (cnt_q >= DataWVal);

  // Frame tracking and word assembly.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    lrc_prev_d = lrc_prev_q;
    shreg_fin  = shreg_q;
    cnt_fin    = cnt_q;
    word_fire  = 1'b0;
    word_data  = '0;
    word_right = lrc_prev_q;

    if (bclk_evt) begin
      to_d = '0;
    end else if (to_q != '1) begin
      to_d = to_q + 1'b1;
    end else begin
      to_d = to_q;
    end

    if (bclk_evt) begin
      lrc_prev_d = lrc_s2_q;
      case (state_q)
        StSync: begin
          if (boundary) begin
            state_d = StRecv;
            cnt_d   = '0;
            shreg_d = '0;
          end
        end
        default: begin
          // Bits beyond DATA_W in a long slot are dropped.
          if (!cnt_full) begin
            shreg_fin = {shreg_q[DATA_W-2:0], sd_s2_q};
            cnt_fin   = cnt_q + 1'b1;
          end
          if (boundary) begin
            // The bit at a boundary is the LSB of the slot that just ended.
            word_fire = (cnt_fin != '0);
            word_data = shreg_fin << (DataWVal - cnt_fin);
            cnt_d     = '0;
            shreg_d   = '0;
          end else begin
            cnt_d   = cnt_fin;
            shreg_d = shreg_fin;
          end
        end
      endcase
    end else if (state_q == StRecv && to_q >= TimeoutVal) begin
      // bclk went quiet: abandon the partial word and hunt for a boundary again.
      state_d = StSync;
      cnt_d   = '0;
      shreg_d = '0;
    end
  end

  // Holding register and overrun accounting.
  always_comb begin
    data_d    = data_q;
    right_d   = right_q;
    valid_d   = valid_q;
    ovr_d     = 1'b0;
    ovr_cnt_d = ovr_cnt_q;

    if (valid_q && sample_ready_i) begin
      valid_d = 1'b0;
    end

    if (word_fire) begin
      if (valid_q && !sample_ready_i) begin
        ovr_d = 1'b1;
        if (ovr_cnt_q != '1) begin
          ovr_cnt_d = ovr_cnt_q + 1'b1;
        end
      end else begin
        data_d  = word_data;
        right_d = word_right;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_hist_q <= 1'b0;
      lrc_s1_q    <= 1'b0;
      lrc_s2_q    <= 1'b0;
      sd_s1_q     <= 1'b0;
      sd_s2_q     <= 1'b0;
      lrc_prev_q  <= 1'b0;
      state_q     <= StSync;
      cnt_q       <= '0;
      shreg_q     <= '0;
      to_q        <= '0;
      data_q      <= '0;
      right_q     <= 1'b0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
      ovr_cnt_q   <= '0;
    end else begin
      bclk_s1_q   <= i2s_bclk_i;
      bclk_s2_q   <= bclk_s1_q;
      bclk_hist_q <= bclk_s2_q;
      lrc_s1_q    <= i2s_lrc_i;
      lrc_s2_q    <= lrc_s1_q;
      sd_s1_q     <= i2s_sd_i;
      sd_s2_q     <= sd_s1_q;
      lrc_prev_q  <= lrc_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      to_q        <= to_d;
      data_q      <= data_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  assign sample_data_o  = data_q;
  assign sample_right_o = right_q;
  assign sample_valid_o = valid_q;
  assign locked_o       = (state_q == StRecv);
  assign overrun_o      = ovr_q;
  assign overrun_cnt_o  = ovr_cnt_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// ---------------------------------------------------------------------------------------------
// tb_i2s_rx_deserializer
//   Drives I2S frames from an event list (lrc/sd value present at each bclk rising edge) and
//   predicts the emitted words slot by slot: a slot runs from one lrc change to the next, its
//   word is the first DATA_W bits after the opening change up to and including the closing one.
// ---------------------------------------------------------------------------------------------
module tb_i2s_rx_deserializer;

  localparam int DW = 16;
  localparam int TO = 255;
  localparam int CW = 8;
  localparam int HALF = 18;  // clk cycles per bclk half period (36x oversampling)

  logic          clk = 1'b0;
  logic          rst;
  logic          bclk, lrc, sd;
  logic [DW-1:0] sample_data;
  logic          sample_right, sample_valid, sample_ready;
  logic          locked, overrun;
  logic [CW-1:0] overrun_cnt;

  i2s_rx_deserializer #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i2s_bclk_i    (bclk),
    .i2s_lrc_i     (lrc),
    .i2s_sd_i      (sd),
    .sample_data_o (sample_data),
    .sample_right_o(sample_right),
    .sample_valid_o(sample_valid),
    .sample_ready_i(sample_ready),
    .locked_o      (locked),
    .overrun_o     (overrun),
    .overrun_cnt_o (overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ov_seen = 0;

  bit ev_lrc[$];
  bit ev_sd[$];
  bit pend;
  bit model_prev;

  logic [DW-1:0] exp_data[$];
  bit            exp_right[$];

  bit rand_ready = 1'b0;
  bit ready_fix  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Consumer ready.
  initial begin
    sample_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sample_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  // Scoreboard: every accepted word must be the next predicted one.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ov_seen++;
      if (sample_valid && sample_ready) begin
        if (exp_data.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h ch %0d, expected no word", sample_data,
                   sample_right);
        end else begin
          logic [DW-1:0] ed;
          bit            er;
          ed = exp_data.pop_front();
          er = exp_right.pop_front();
          check("word_data", 32'(sample_data), 32'(ed));
          check("word_chan", 32'(sample_right), 32'(er));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---- event list construction (sd is the data stream delayed by one bclk) ----
  task automatic clear_events();
    ev_lrc.delete();
    ev_sd.delete();
    pend = 1'($urandom_range(0, 1));
  endtask

  task automatic push_ev(input bit c, input bit b);
    ev_lrc.push_back(c);
    ev_sd.push_back(pend);
    pend = b;
  endtask

  task automatic add_partial(input bit c, input int n);
    for (int i = 0; i < n; i++) push_ev(c, 1'($urandom_range(0, 1)));
  endtask

  task automatic add_slot(input bit c, input int n, input logic [31:0] w);
    for (int k = n - 1; k >= 0; k--) push_ev(c, w[k]);
  endtask

  task automatic add_close(input bit c);
    push_ev(c, 1'($urandom_range(0, 1)));
  endtask

  // ---- behavioural model: slot-by-slot word prediction ----
  task automatic run_model();
    int b[$];
    bit p;
    p = model_prev;
    for (int i = 0; i < ev_lrc.size(); i++) begin
      if (ev_lrc[i] != p) b.push_back(i);
      p = ev_lrc[i];
    end
    for (int j = 0; j + 1 < b.size(); j++) begin
      int            s, n;
      logic [DW-1:0] w;
      s = b[j];
      n = b[j+1] - s;
      if (n > DW) n = DW;
      w = '0;
      for (int k = 0; k < n; k++) w[DW-1-k] = ev_sd[s+1+k];
      exp_data.push_back(w);
      exp_right.push_back(ev_lrc[s]);
    end
    model_prev = p;
  endtask

  task automatic drive(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(posedge clk);
      #1;
      bclk = 1'b0;
      lrc  = ev_lrc[i];
      sd   = ev_sd[i];
      repeat (HALF) @(posedge clk);
      #1;
      bclk = 1'b1;
      repeat (HALF - 1) @(posedge clk);
    end
    @(posedge clk);
    #1;
    bclk = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_data.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(name, 32'(exp_data.size()), 32'd0);
    exp_data.delete();
    exp_right.delete();
  endtask

  task automatic gap(input string name);
    repeat (TO + 45) @(posedge clk);
    #1;
    check(name, 32'(locked), 32'd0);
  endtask

  task automatic std_frame();
    int p_end;
    clear_events();
    add_partial(1'b0, 5);
    p_end = ev_lrc.size();
    add_slot(1'b1, 16, 32'h7FFE);
    add_slot(1'b0, 16, 32'h8001);
    add_slot(1'b1, 16, 32'h7FFE);
    add_close(1'b0);
    run_model();
    check("t1_count", 32'(exp_data.size()), 32'd3);
    check("t1_w0", 32'(exp_data[0]), 32'h7FFE);
    check("t1_c0", 32'(exp_right[0]), 32'd1);
    check("t1_w1", 32'(exp_data[1]), 32'h8001);
    check("t1_c1", 32'(exp_right[1]), 32'd0);
    drive(0, p_end);
    check("t1_unlocked_partial", 32'(locked), 32'd0);
    drive(p_end, p_end + 1);
    check("t1_locked_boundary", 32'(locked), 32'd1);
    drive(p_end + 1, ev_lrc.size());
    drain("t1_drain");
    check("t1_locked_end", 32'(locked), 32'd1);
    gap("t1_unlock_gap");
  endtask

  initial begin
    int k, qb, n;
    bit c;
    logic [31:0] wa, wb, wc;

    rst = 1'b1;
    bclk = 1'b0;
    lrc = 1'b0;
    sd = 1'b0;
    model_prev = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_data", 32'(sample_data), 32'd0);
    check("rst_right", 32'(sample_right), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_ovcnt", 32'(overrun_cnt), 32'd0);

    // 1: 16-bit slots, partial slot before first boundary never emitted.
    std_frame();

    // 2: 32-bit slots, only the first DW bits kept.
    clear_events();
    add_partial(model_prev, 3);
    add_slot(!model_prev, 32, $urandom);
    add_slot(model_prev, 32, 32'h12345678);
    add_slot(!model_prev, 32, $urandom);
    add_close(model_prev);
    run_model();
    check("t2_count", 32'(exp_data.size()), 32'd3);
    check("t2_w1", 32'(exp_data[1]), 32'h1234);
    drive(0, ev_lrc.size());
    drain("t2_drain");
    gap("t2_gap");

    // 3: 8-bit slots, left-justified with zero LSBs.
    clear_events();
    add_partial(model_prev, 3);
    add_slot(!model_prev, 8, 32'h3C);
    add_slot(model_prev, 8, 32'hA5);
    add_close(!model_prev);
    run_model();
    check("t3_w0", 32'(exp_data[0]), 32'h3C00);
    check("t3_w1", 32'(exp_data[1]), 32'hA500);
    drive(0, ev_lrc.size());
    drain("t3_drain");
    gap("t3_gap");

    // 4: consumer stalls across two finished words.
    ready_fix = 1'b0;
    wa = 32'h1357;
    wb = 32'h2468;
    wc = 32'h9ABC;
    clear_events();
    add_partial(model_prev, 2);
    add_slot(!model_prev, 16, wa);
    add_slot(model_prev, 16, wb);
    k = ev_lrc.size();
    add_slot(!model_prev, 16, wc);
    add_close(model_prev);
    qb = exp_data.size();
    run_model();
    check("t4_wb_predicted", 32'(exp_data[qb+1]), wb);
    exp_data.delete(qb + 1);
    exp_right.delete(qb + 1);
    drive(0, k + 1);
    check("t4_valid_held", 32'(sample_valid), 32'd1);
    check("t4_data_held", 32'(sample_data), wa);
    check("t4_ovcnt", 32'(overrun_cnt), 32'd1);
    check("t4_ov_pulses", 32'(ov_seen), 32'd1);
    ready_fix = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t4_valid_fall", 32'(sample_valid), 32'd0);
    drive(k + 1, ev_lrc.size());
    drain("t4_drain");
    check("t4_ovcnt_end", 32'(overrun_cnt), 32'd1);
    check("t4_ov_pulses_end", 32'(ov_seen), 32'd1);
    gap("t4_gap");

    // 5: bclk stops mid-slot; relock afterwards.
    rand_ready = 1'b1;
    clear_events();
    add_partial(model_prev, 3);
    add_slot(!model_prev, 16, $urandom);
    add_slot(model_prev, 16, $urandom);
    add_partial(!model_prev, 7);
    run_model();
    drive(0, ev_lrc.size());
    check("t5_locked_before_stop", 32'(locked), 32'd1);
    drain("t5_drain_a");
    gap("t5_unlock");
    clear_events();
    add_partial(model_prev, 4);
    add_slot(!model_prev, 16, $urandom);
    add_slot(model_prev, 16, $urandom);
    add_close(!model_prev);
    run_model();
    check("t5_relock_words", 32'(exp_data.size()), 32'd2);
    drive(0, ev_lrc.size());
    drain("t5_drain_b");
    gap("t5_gap");

    // 6: reset mid-slot with a word pending.
    rand_ready = 1'b0;
    ready_fix = 1'b0;
    clear_events();
    add_partial(model_prev, 3);
    add_slot(!model_prev, 16, $urandom);
    add_partial(model_prev, 5);
    run_model();
    drive(0, ev_lrc.size());
    check("t6_valid_pre", 32'(sample_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_data.delete();
    exp_right.delete();
    check("t6_valid", 32'(sample_valid), 32'd0);
    check("t6_locked", 32'(locked), 32'd0);
    check("t6_ovcnt", 32'(overrun_cnt), 32'd0);
    check("t6_data", 32'(sample_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_prev = 1'b0;
    ov_seen = 0;
    ready_fix = 1'b1;
    repeat (3) @(posedge clk);
    std_frame();

    // Randomised frames with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      case ($urandom_range(0, 4))
        0: n = 8;
        1: n = 12;
        2: n = 16;
        3: n = 24;
        default: n = 32;
      endcase
      clear_events();
      c = 1'($urandom_range(0, 1));
      add_partial(c, $urandom_range(1, 6));
      k = $urandom_range(2, 3);
      for (int s = 0; s < k; s++) begin
        c = !c;
        add_slot(c, n, $urandom);
      end
      add_close(!c);
      run_model();
      drive(0, ev_lrc.size());
      check("rand_locked", 32'(locked), 32'd1);
      drain("rand_drain");
      gap("rand_gap");
    end
    check("final_ovcnt", 32'(overrun_cnt), 32'd0);
    check("final_ov_pulses", 32'(ov_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
